seg7_bcd_decoder: RTL

SEG7_BCD_DECODER -- requirements
Module: seg7_bcd_decoder

---
 rtl/seg7_bcd_decoder_if.sv | 22 ++
 rtl/seg7_bcd_decoder.sv | 90 +++++++++
 2 files changed

// File: rtl/seg7_bcd_decoder_if.sv
// Handshake bundle between a seven-segment pattern producer and a BCD pair consumer.
interface seg7_bcd_decoder_if;
   logic       in_valid;
   logic       in_ready;
   logic [6:0] in_seg;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_tens;
   logic [3:0] out_ones;
   logic       out_err;
   logic [7:0] err_count;

   modport master (
      output in_valid, in_seg, out_ready,
      input  in_ready, out_valid, out_tens, out_ones, out_err, err_count
   );

   modport slave (
      input  in_valid, in_seg, out_ready,
      output in_ready, out_valid, out_tens, out_ones, out_err, err_count
   );
endinterface

// File: rtl/seg7_bcd_decoder.sv
// Pairs two active-low seven-segment patterns into a BCD tens/ones result.
// Result appears one cycle after the second transfer and is held until taken.
module seg7_bcd_decoder (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   seg7_bcd_decoder_if.slave  bus
);

   typedef enum logic [1:0] {S_TENS, S_ONES, S_OUT} state_t;

   state_t     state;
   logic [3:0] tens_q;
   logic       tens_bad_q;
   logic [3:0] out_tens_q;
   logic [3:0] out_ones_q;
   logic       out_err_q;
   logic [7:0] err_cnt_q;
   logic [4:0] dec;

   // Returns {invalid, digit}; anything outside the ten glyphs reads as F.
   function automatic logic [4:0] decode(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'b0000001: r = 5'h00;
         7'b1001111: r = 5'h01;
         7'b0010010: r = 5'h02;
         7'b0000110: r = 5'h03;
         7'b1001100: r = 5'h04;
         7'b0100100: r = 5'h05;
         7'b0100000: r = 5'h06;
         7'b0001111: r = 5'h07;
         7'b0000000: r = 5'h08;
         7'b0001100: r = 5'h09;
         default:    r = 5'h1F;
      endcase
      return r;
   endfunction

   assign dec = decode(bus.in_seg);

   assign bus.in_ready  = (state != S_OUT);
   assign bus.out_valid = (state == S_OUT);
   assign bus.out_tens  = out_tens_q;
   assign bus.out_ones  = out_ones_q;
   assign bus.out_err   = out_err_q;
   assign bus.err_count = err_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_TENS;
         tens_q     <= 4'h0;
         tens_bad_q <= 1'b0;
         out_tens_q <= 4'h0;
         out_ones_q <= 4'h0;
         out_err_q  <= 1'b0;
         err_cnt_q  <= 8'h00;
      end else if (flush) begin
         // Published outputs stay put; only the pairing progress is dropped.
         state <= S_TENS;
      end else begin
         case (state)
            S_TENS: begin
               if (bus.in_valid) begin
                  tens_q     <= dec[3:0];
                  tens_bad_q <= dec[4];
                  state      <= S_ONES;
               end
            end
            S_ONES: begin
               if (bus.in_valid) begin
                  out_tens_q <= tens_q;
                  out_ones_q <= dec[3:0];
                  out_err_q  <= tens_bad_q | dec[4];
                  state      <= S_OUT;
               end
            end
            S_OUT: begin
               if (bus.out_ready) begin
                  if (out_err_q && (err_cnt_q != 8'hFF))
                     err_cnt_q <= err_cnt_q + 8'd1;
                  state <= S_TENS;
               end
            end
            default: state <= S_TENS;
         endcase
      end
   end

endmodule
